// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions: datapath widths, the hard-wired zero register
// and the WB control bundle carried from the decoder down to MEM/WB.
package mem_wb_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [4:0] ZERO_REG = 5'd0;

    // WB control bits as produced by the control decoder and carried by
    // every upstream pipe register.
    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_ctrl_t;

endpackage : mem_wb_stage_pkg

// File: rtl/mem_wb_stage_wb_select.sv
// Write-back select: MemtoReg data mux plus write-enable qualification.
// Purely combinational so the forwarding unit can reuse it on any stage.
module wb_select
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              valid_i,
    input  wb_ctrl_t          ctrl_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [REG_AW-1:0] dest_i,
    output logic              we_o,
    output logic [DATA_W-1:0] wdata_o
);

    // Loads return memory data, everything else the ALU result; a write
    // needs a real entry, RegWrite, and a destination other than $zero.
    always_comb begin
        wdata_o = ctrl_i.memtoreg ? rdata_i : alu_i;
        we_o    = valid_i & ctrl_i.regwrite & (dest_i != REG_AW'(ZERO_REG));
    end

endmodule : wb_select

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, register-file write-back port, forwarding source
// and a saturating retired-instruction counter for debug.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = mem_wb_stage_pkg::DATA_W,
    parameter int REG_AW = mem_wb_stage_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              memtoreg_i,
    input  logic              regwrite_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic [REG_AW-1:0] dest_reg_i,
    input  logic              cnt_clr_i,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              fwd_valid_o,
    output logic              wb_valid_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    logic              valid_q, valid_d;
    wb_ctrl_t          ctrl_q, ctrl_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Capture priority: flush turns the slot into a bubble (data held),
    // stall holds everything, otherwise load the MEM-stage entry.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        dest_d  = dest_q;
        if (flush_i) begin
            valid_d         = 1'b0;
            ctrl_d.regwrite = 1'b0;
        end else if (!stall_i) begin
            valid_d = valid_i;
            ctrl_d  = '{memtoreg: memtoreg_i, regwrite: regwrite_i};
            alu_d   = alu_result_i;
            rdata_d = mem_rdata_i;
            dest_d  = dest_reg_i;
        end
    end

    // An entry retires when it leaves WB (valid and not stalled); clear wins,
    // and the count sticks at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (valid_q && !stall_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline and counter state; every register resets so nothing goes X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
        end
    end

    wb_select #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_wb_select (
        .valid_i (valid_q),
        .ctrl_i  (ctrl_q),
        .alu_i   (alu_q),
        .rdata_i (rdata_q),
        .dest_i  (dest_q),
        .we_o    (rf_we_o),
        .wdata_o (rf_wdata_o)
    );

    // A stalled valid entry keeps rf_we_o high; the repeated write is harmless.
    assign rf_waddr_o   = dest_q;
    assign fwd_valid_o  = rf_we_o;
    assign wb_valid_o   = valid_q;
    assign retire_cnt_o = cnt_q;

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table plus multi-cycle sequences
// for counter saturation/clear and asynchronous reset.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_i, flush_i, valid_i, memtoreg_i, regwrite_i, cnt_clr_i;
    logic [DW-1:0] alu_result_i, mem_rdata_i;
    logic [AW-1:0] dest_reg_i;
    logic          rf_we_o, fwd_valid_o, wb_valid_o;
    logic [AW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic [CW-1:0] retire_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .memtoreg_i   (memtoreg_i),
        .regwrite_i   (regwrite_i),
        .alu_result_i (alu_result_i),
        .mem_rdata_i  (mem_rdata_i),
        .dest_reg_i   (dest_reg_i),
        .cnt_clr_i    (cnt_clr_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .fwd_valid_o  (fwd_valid_o),
        .wb_valid_o   (wb_valid_o),
        .retire_cnt_o (retire_cnt_o)
    );

    typedef struct {
        logic          stall, flush, valid, m2r, rw, clr;
        logic [DW-1:0] alu, rdata;
        logic [AW-1:0] dest;
        logic          e_we;
        logic [AW-1:0] e_waddr;
        logic [DW-1:0] e_wdata;
        logic          e_wbv;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic st, logic fl, logic v, logic m2r, logic rw,
                                logic clr, logic [DW-1:0] alu, logic [DW-1:0] rd,
                                logic [AW-1:0] dst, logic we, logic [AW-1:0] wa,
                                logic [DW-1:0] wd, logic wbv, logic [CW-1:0] cnt);
        vec_t r;
        r.stall = st;  r.flush = fl; r.valid = v; r.m2r = m2r; r.rw = rw; r.clr = clr;
        r.alu = alu;   r.rdata = rd; r.dest = dst;
        r.e_we = we;   r.e_waddr = wa; r.e_wdata = wd; r.e_wbv = wbv; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic we, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd, input logic wbv, input logic [CW-1:0] cnt);
        chk({tag, ".rf_we"},    64'(rf_we_o),      64'(we));
        chk({tag, ".fwd_vld"},  64'(fwd_valid_o),  64'(we));
        chk({tag, ".waddr"},    64'(rf_waddr_o),   64'(wa));
        chk({tag, ".wdata"},    64'(rf_wdata_o),   64'(wd));
        chk({tag, ".wb_valid"}, 64'(wb_valid_o),   64'(wbv));
        chk({tag, ".cnt"},      64'(retire_cnt_o), 64'(cnt));
    endtask

    task automatic drive(input logic st, input logic fl, input logic v, input logic m2r,
                         input logic rw, input logic clr, input logic [DW-1:0] alu,
                         input logic [DW-1:0] rd, input logic [AW-1:0] dst);
        stall_i = st; flush_i = fl; valid_i = v; memtoreg_i = m2r; regwrite_i = rw;
        cnt_clr_i = clr; alu_result_i = alu; mem_rdata_i = rd; dest_reg_i = dst;
    endtask

    initial begin
        // Expected outputs are those seen after the edge that samples the row.
        //                st fl v  m2r rw clr alu           rdata         dst    we wa  wdata         wbv cnt
        vecs[0]  = mk(0, 0, 1, 0, 1, 0, 32'h0000_0010, 32'h0,         5'd8,  1, 8,  32'h10,        1, 0); // R-type
        vecs[1]  = mk(0, 0, 1, 1, 1, 0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd9,  1, 9,  32'hDEAD_BEEF, 1, 1); // lw
        vecs[2]  = mk(0, 0, 1, 0, 0, 0, 32'h0000_0200, 32'h1,         5'd5,  0, 5,  32'h200,       1, 2); // sw
        vecs[3]  = mk(0, 0, 1, 0, 1, 0, 32'h0000_0033, 32'h2,         5'd0,  0, 0,  32'h33,        1, 3); // $zero
        vecs[4]  = mk(0, 0, 0, 0, 1, 0, 32'h0000_0044, 32'h3,         5'd7,  0, 7,  32'h44,        0, 4); // bubble
        vecs[5]  = mk(1, 0, 1, 0, 1, 0, 32'h0000_0055, 32'h4,         5'd3,  0, 7,  32'h44,        0, 4); // stall bubble
        vecs[6]  = mk(0, 0, 1, 1, 1, 0, 32'h0000_0300, 32'hCAFE_F00D, 5'd10, 1, 10, 32'hCAFE_F00D, 1, 4); // lw
        vecs[7]  = mk(1, 0, 1, 0, 1, 0, 32'h0000_0AAA, 32'h5,         5'd11, 1, 10, 32'hCAFE_F00D, 1, 4); // stall 1
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 32'h0000_0BBB, 32'h6,         5'd12, 1, 10, 32'hCAFE_F00D, 1, 4); // stall 2
        vecs[9]  = mk(1, 0, 1, 1, 0, 0, 32'h0000_0CCC, 32'h7,         5'd13, 1, 10, 32'hCAFE_F00D, 1, 4); // stall 3
        vecs[10] = mk(0, 0, 1, 0, 1, 0, 32'h0000_0077, 32'h8,         5'd12, 1, 12, 32'h77,        1, 5); // release
        vecs[11] = mk(1, 1, 1, 0, 1, 0, 32'h0000_0088, 32'h9,         5'd13, 0, 12, 32'h77,        0, 5); // flush+stall
        vecs[12] = mk(0, 0, 1, 0, 1, 1, 32'h0000_0001, 32'hA,         5'd1,  1, 1,  32'h1,         1, 0); // clr
        vecs[13] = mk(0, 1, 1, 0, 1, 0, 32'h0000_0002, 32'hB,         5'd2,  0, 1,  32'h1,         0, 1); // flush
        vecs[14] = mk(0, 0, 1, 1, 1, 0, 32'h0000_0003, 32'h1234_5678, 5'd31, 1, 31, 32'h1234_5678, 1, 1); // lw r31

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, '0, '0, '0);
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].m2r, vecs[i].rw,
                  vecs[i].clr, vecs[i].alu, vecs[i].rdata, vecs[i].dest);
            @(posedge clk);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_waddr,
                    vecs[i].e_wdata, vecs[i].e_wbv, vecs[i].e_cnt);
        end

        // Saturation: valid_q=1 and cnt=1 here; 20 more retiring edges go well past 15.
        drive(0, 0, 1, 0, 1, 0, 32'h0000_0099, '0, 5'd4);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sat.cnt", 64'(retire_cnt_o), 64'hF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat.hold", 64'(retire_cnt_o), 64'hF);
        cnt_clr_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("clr.cnt", 64'(retire_cnt_o), 64'h0);
        cnt_clr_i = 1'b0;

        // Asynchronous reset between edges while a valid entry is stalled.
        drive(0, 0, 1, 1, 1, 0, 32'h0000_0500, 32'h0BAD_F00D, 5'd6);
        @(posedge clk);
        @(negedge clk);
        chk_all("pre_rst", 1, 6, 32'h0BAD_F00D, 1, 1);
        stall_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all("post_rst_stall", 0, 0, 0, 0, 0);
        stall_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all("post_rst_load", 1, 6, 32'h0BAD_F00D, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mem_wb_stage

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and write-back select for the 5-stage MIPS pipeline. It captures the WB control bits produced by the WB control decoder (MemtoReg, RegWrite) once they have travelled through the earlier pipe registers, together with the ALU result, load data and destination register. It then drives the register-file write port and the forwarding-unit source. It also contains a saturating retired-instruction counter for debug.

Parameters:
DATA_W, 32, datapath width of ALU result, load data and write-back data
REG_AW, 5, register-file address width
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hold MEM/WB contents (hazard unit / memory not ready)
flush_i  in  1  replace captured entry with a bubble
valid_i  in  1  MEM-stage entry is a real instruction
memtoreg_i  in  1  WB control: 1 = write load data, 0 = write ALU result
regwrite_i  in  1  WB control: instruction writes a register
alu_result_i  in  DATA_W  ALU result from EX/MEM
mem_rdata_i  in  DATA_W  data-memory read data for this entry
dest_reg_i  in  REG_AW  destination register (rd/rt already selected upstream)
cnt_clr_i  in  1  synchronous clear of retire counter
rf_we_o  out  1  register-file write enable
rf_waddr_o  out  REG_AW  register-file write address
rf_wdata_o  out  DATA_W  register-file write data
fwd_valid_o  out  1  forwarding source valid (same condition as rf_we_o)
wb_valid_o  out  1  registered entry valid
retire_cnt_o  out  CNT_W  number of valid entries that completed WB

Behaviour:
- Reset (rst_n=0, async): valid_q=0, memtoreg_q=0, regwrite_q=0, alu_q=0, rdata_q=0, dest_q=0, retire_cnt=0. All outputs therefore read 0.
- Capture priority on each rising edge:
  - flush_i=1: valid_q<=0 and regwrite_q<=0. Data fields are don't-care and held. Flush overrides stall.
  - else stall_i=1: all fields hold.
  - else: all fields load from their *_i inputs.
- Latency: one cycle from MEM inputs to rf_* outputs.
- rf_wdata_o is combinational from registered fields: memtoreg_q ? rdata_q : alu_q. Full DATA_W, no extension.
- rf_we_o = valid_q & regwrite_q & (dest_q != 0). Writes to $zero are suppressed.
- rf_waddr_o = dest_q.
- fwd_valid_o = rf_we_o. wb_valid_o = valid_q.
- Stall with a valid entry: rf_we_o stays asserted every stalled cycle with the same address and data. The repeated write is idempotent; the register file tolerates it.
- Retire counter:
  - cnt_clr_i=1: counter goes to 0 next edge. Clear has priority over increment.
  - else increments by 1 on each edge where valid_q=1 and stall_i=0. This counts an entry once, when it leaves WB.
  - Saturates at all-ones; no wrap.
- Bubble entry (valid_q=0): rf_we_o=0 regardless of regwrite_q. rf_wdata_o is still driven but meaningless.
- Reset mid-stall or mid-flush: reset wins immediately and asynchronously. The first post-reset edge behaves per the capture priority above.
- No X propagation: every register has a reset value.

Decomposition:
- Shared pipeline package holds:
  - DATA_W / REG_AW constants
  - ZERO_REG = 5'd0
  - packed wb_ctrl_t {memtoreg, regwrite}, the same type the WB control decoder and upstream pipe registers carry
- One natural sub-module: wb_select, the combinational MemtoReg mux plus write-enable qualification. It is reusable by the forwarding unit.
- The retire counter is inline.

Test Plan:
- R-type: valid_i=1, regwrite_i=1, memtoreg_i=0, alu_result_i=0x0000_0010, dest=8 -> next cycle rf_we_o=1, rf_waddr_o=8, rf_wdata_o=0x10, retire_cnt_o increments 0->1 one edge later.
- lw: memtoreg_i=1, regwrite_i=1, mem_rdata_i=0xDEAD_BEEF, alu_result_i=0x100, dest=9 -> rf_wdata_o=0xDEADBEEF, rf_we_o=1.
- sw/beq (regwrite_i=0), or any instruction with dest=0 and regwrite_i=1 -> rf_we_o=0, fwd_valid_o=0, wb_valid_o=1.
- Stall: load lw entry, hold stall_i=1 for 3 cycles while inputs change -> outputs constant, rf_we_o=1 all 3 cycles, retire_cnt unchanged until stall drops, then +1 exactly once.
- Flush with stall: stall_i=1 and flush_i=1 with a valid entry held -> next cycle wb_valid_o=0, rf_we_o=0.
- Reset/counter: assert rst_n=0 asynchronously between edges with valid entry -> outputs 0 immediately. Preload counter to all-ones (CNT_W=4 config, 16 retires) -> stays 0xF; cnt_clr_i=1 -> 0.
